mac_apb_stat_regs7: RTL and testbench

//  APB slave register bank for one MAC port. Sits directly downstream of the AHB-to-APB bridge on a psel_macN/pready_macN/prdata_macN slot.

---
 rtl/mac_regs_pkg7.sv | 29 ++
 rtl/sat_counter7.sv | 38 +++
 rtl/mac_apb_stat_regs7.sv | 159 +++++++++++++++
 tb/tb_mac_apb_stat_regs7.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_regs_pkg7.sv
// Shared definitions for the MAC port APB register bank: register map,
// interrupt bit positions, default ID value and the APB slave FSM encoding.
package mac_regs_pkg7;

  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_STATUS     = 8'h04;
  localparam logic [7:0] ADDR_INT_STATUS = 8'h08;
  localparam logic [7:0] ADDR_INT_MASK   = 8'h0C;
  localparam logic [7:0] ADDR_CNT0       = 8'h10;
  localparam logic [7:0] ADDR_CNT1       = 8'h14;
  localparam logic [7:0] ADDR_CNT2       = 8'h18;
  localparam logic [7:0] ADDR_CNT3       = 8'h1C;
  localparam logic [7:0] ADDR_ID         = 8'h20;

  localparam int NUM_CNT  = 4;
  localparam int INT_CNT0 = 0;
  localparam int INT_CNT1 = 1;
  localparam int INT_CNT2 = 2;
  localparam int INT_CNT3 = 3;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4D41_4301;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_e;

endpackage

// File: rtl/sat_counter7.sv
// Saturating event counter with clear-on-read; sat_pulse flags every event
// that leaves the counter at its maximum value.
module sat_counter7 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             sat_pulse
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] value_q, value_d;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      // An event landing on the clearing read is counted, not lost.
      value_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (value_q != MAX)) begin
      value_d = value_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value     = value_q;
  assign sat_pulse = inc && (value_d == MAX);

endmodule

// File: rtl/mac_apb_stat_regs7.sv
// APB slave register bank for one MAC port: control/status, four saturating
// clear-on-read event counters, masked interrupt and programmable wait states.
module mac_apb_stat_regs7
  import mac_regs_pkg7::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic        pclk7,
  input  logic        preset7,
  input  logic        psel7,
  input  logic        penable7,
  input  logic        pwrite7,
  input  logic [7:0]  paddr7,
  input  logic [31:0] pwdata7,
  output logic [31:0] prdata7,
  output logic        pready7,
  input  logic [3:0]  ev7,
  input  logic        link_up7,
  output logic [7:0]  ctrl7,
  output logic        irq7
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  apb_state_e state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic       access_cyc;
  logic       wr_en, rd_en;
  logic [7:0] waddr;

  logic [7:0] ctrl_q, ctrl_d;
  logic [3:0] int_status_q, int_status_d;
  logic [3:0] int_mask_q, int_mask_d;
  logic       irq_q;
  logic [3:0] w1c;
  logic [31:0] rdata;

  logic [CNT_W-1:0] cnt_val [NUM_CNT];
  logic [31:0]      cnt_ext [NUM_CNT];
  logic [3:0]       cnt_clr;
  logic [3:0]       sat_pulse;

  logic unused_bits;
  assign unused_bits = ^{pwdata7[31:8], paddr7[1:0]};

  // The first access cycle is seen while the FSM is still in SETUP, which keeps
  // WAIT_STATES=0 a two-cycle transfer.
  assign access_cyc = psel7 && penable7 && (state_q != ST_IDLE);
  assign pready7    = access_cyc && (wcnt_q == WS);
  assign wr_en      = pready7 && pwrite7;
  assign rd_en      = pready7 && !pwrite7;
  assign waddr      = {paddr7[7:2], 2'b00};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        wcnt_d = '0;
        if (psel7 && !penable7) state_d = ST_SETUP;
      end
      ST_SETUP, ST_ACCESS: begin
        if (!psel7) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (penable7) begin
          if (pready7) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
          end else begin
            state_d = ST_ACCESS;
            wcnt_d  = wcnt_q + 3'd1;
          end
        end else begin
          state_d = ST_SETUP;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    localparam logic [7:0] CNT_ADDR = ADDR_CNT0 + 8'(4 * k);

    assign cnt_clr[k] = rd_en && (waddr == CNT_ADDR);
    assign cnt_ext[k] = 32'(cnt_val[k]);

    sat_counter7 #(.CNT_W(CNT_W)) u_cnt (
      .clk       (pclk7),
      .rst       (preset7),
      .inc       (ev7[k]),
      .clr       (cnt_clr[k]),
      .value     (cnt_val[k]),
      .sat_pulse (sat_pulse[k])
    );
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    int_mask_d = int_mask_q;
    w1c        = '0;
    if (wr_en) begin
      case (waddr)
        ADDR_CTRL:       ctrl_d     = pwdata7[7:0];
        ADDR_INT_STATUS: w1c        = pwdata7[3:0];
        ADDR_INT_MASK:   int_mask_d = pwdata7[3:0];
        default:         ;
      endcase
    end
    // A saturation event in the W1C cycle wins over the clear.
    int_status_d = (int_status_q & ~w1c) | sat_pulse;
  end

  always_comb begin
    rdata = '0;
    case (waddr)
      ADDR_CTRL:       rdata = {24'b0, ctrl_q};
      ADDR_STATUS:     rdata = {31'b0, link_up7};
      ADDR_INT_STATUS: rdata = {28'b0, int_status_q};
      ADDR_INT_MASK:   rdata = {28'b0, int_mask_q};
      ADDR_CNT0:       rdata = cnt_ext[INT_CNT0];
      ADDR_CNT1:       rdata = cnt_ext[INT_CNT1];
      ADDR_CNT2:       rdata = cnt_ext[INT_CNT2];
      ADDR_CNT3:       rdata = cnt_ext[INT_CNT3];
      ADDR_ID:         rdata = ID_VALUE;
      default:         rdata = '0;
    endcase
  end

  assign prdata7 = pready7 ? rdata : '0;

  always_ff @(posedge pclk7) begin
    if (preset7) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      ctrl_q       <= '0;
      int_status_q <= '0;
      int_mask_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      ctrl_q       <= ctrl_d;
      int_status_q <= int_status_d;
      int_mask_q   <= int_mask_d;
      irq_q        <= |(int_status_q & int_mask_q);
    end
  end

  assign ctrl7 = ctrl_q;
  assign irq7  = irq_q;

endmodule

// File: tb/tb_mac_apb_stat_regs7.sv
// Directed bench for mac_apb_stat_regs7 (WAIT_STATES=2, CNT_W=4): a table of
// single APB transfers plus hand-written multi-cycle sequences.
module tb_mac_apb_stat_regs7;

  localparam int WS = 2;
  localparam int CW = 4;

  logic        pclk7 = 1'b0;
  logic        preset7, psel7, penable7, pwrite7;
  logic [7:0]  paddr7;
  logic [31:0] pwdata7, prdata7;
  logic        pready7;
  logic [3:0]  ev7;
  logic        link_up7;
  logic [7:0]  ctrl7;
  logic        irq7;

  int checks = 0;
  int errors = 0;
  logic [7:0] ctrl_at_ready;

  always #5 pclk7 = ~pclk7;

  mac_apb_stat_regs7 #(.WAIT_STATES(WS), .CNT_W(CW), .ID_VALUE(32'h4D41_4301)) dut (
    .pclk7    (pclk7),
    .preset7  (preset7),
    .psel7    (psel7),
    .penable7 (penable7),
    .pwrite7  (pwrite7),
    .paddr7   (paddr7),
    .pwdata7  (pwdata7),
    .prdata7  (prdata7),
    .pready7  (pready7),
    .ev7      (ev7),
    .link_up7 (link_up7),
    .ctrl7    (ctrl7),
    .irq7     (irq7)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        link;
    logic        chk_rd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete APB transfer; ev_at_ready is driven during the pready7 cycle.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [3:0] ev_at_ready, output logic [31:0] rdata, output int waits);
    @(negedge pclk7);
    psel7 = 1'b1; penable7 = 1'b0; pwrite7 = wr; paddr7 = addr; pwdata7 = wdata;
    @(negedge pclk7);
    penable7 = 1'b1;
    waits = 0;
    rdata = '0;
    #1;
    while (!pready7 && waits < 16) begin
      @(negedge pclk7);
      #1;
      waits++;
    end
    if (!pready7) begin
      checks++;
      errors++;
      $display("FAIL apb_timeout addr=0x%02h: pready7 stayed 0 for %0d cycles", addr, waits);
    end else begin
      rdata         = prdata7;
      ctrl_at_ready = ctrl7;
      ev7           = ev_at_ready;
    end
    @(negedge pclk7);
    psel7 = 1'b0; penable7 = 1'b0; pwrite7 = 1'b0; ev7 = '0;
  endtask

  task automatic pulse_ev(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk7);
      ev7[k] = 1'b1;
      @(negedge pclk7);
      ev7[k] = 1'b0;
    end
  endtask

  task automatic start_ctrl_write(input logic [31:0] wdata);
    @(negedge pclk7);
    psel7 = 1'b1; penable7 = 1'b0; pwrite7 = 1'b1; paddr7 = 8'h00; pwdata7 = wdata;
    @(negedge pclk7);
    penable7 = 1'b1;
    #1;
  endtask

  logic [31:0] rd;
  int          w;

  initial begin
    vecs[0]  = '{1'b0, 8'h20, 32'h0,        1'b0, 1'b1, 32'h4D41_4301, "tbl_id"};
    vecs[1]  = '{1'b0, 8'h22, 32'h0,        1'b0, 1'b1, 32'h4D41_4301, "tbl_id_lowbits"};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0000_00A5, "tbl_ctrl"};
    vecs[3]  = '{1'b0, 8'h03, 32'h0,        1'b0, 1'b1, 32'h0000_00A5, "tbl_ctrl_lowbits"};
    vecs[4]  = '{1'b0, 8'h04, 32'h0,        1'b1, 1'b1, 32'h0000_0001, "tbl_status_up"};
    vecs[5]  = '{1'b0, 8'h04, 32'h0,        1'b0, 1'b1, 32'h0000_0000, "tbl_status_down"};
    vecs[6]  = '{1'b0, 8'h24, 32'h0,        1'b0, 1'b1, 32'h0000_0000, "tbl_unmapped_rd"};
    vecs[7]  = '{1'b1, 8'h24, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,        "tbl_unmapped_wr"};
    vecs[8]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0000_00A5, "tbl_ctrl_kept"};
    vecs[9]  = '{1'b1, 8'h0C, 32'h0000_00FF, 1'b0, 1'b0, 32'h0,        "tbl_mask_wr"};
    vecs[10] = '{1'b0, 8'h0C, 32'h0,        1'b0, 1'b1, 32'h0000_000F, "tbl_mask_rd"};
    vecs[11] = '{1'b1, 8'h0C, 32'h0,        1'b0, 1'b0, 32'h0,        "tbl_mask_clr"};
    vecs[12] = '{1'b0, 8'h0C, 32'h0,        1'b0, 1'b1, 32'h0000_0000, "tbl_mask_rd0"};
    vecs[13] = '{1'b1, 8'h00, 32'h0000_015A, 1'b0, 1'b0, 32'h0,        "tbl_ctrl_wr"};
    vecs[14] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0000_005A, "tbl_ctrl_rd"};
    vecs[15] = '{1'b0, 8'h08, 32'h0,        1'b0, 1'b1, 32'h0000_0000, "tbl_int_status"};
    vecs[16] = '{1'b0, 8'hFC, 32'h0,        1'b0, 1'b1, 32'h0000_0000, "tbl_unmapped_top"};

    preset7 = 1'b1; psel7 = 1'b0; penable7 = 1'b0; pwrite7 = 1'b0;
    paddr7 = '0; pwdata7 = '0; ev7 = '0; link_up7 = 1'b0;

    // Reset
    repeat (2) @(posedge pclk7);
    @(negedge pclk7);
    preset7 = 1'b0;
    check("rst_ctrl7", 32'(ctrl7), 32'h0);
    check("rst_irq7", 32'(irq7), 32'h0);
    check("rst_pready7", 32'(pready7), 32'h0);
    check("rst_prdata7", prdata7, 32'h0);
    apb(1'b0, 8'h20, 32'h0, 4'h0, rd, w);
    check("rst_id", rd, 32'h4D41_4301);
    apb(1'b0, 8'h00, 32'h0, 4'h0, rd, w);
    check("rst_ctrl_reg", rd, 32'h0);

    // Wait states and write commit timing
    apb(1'b1, 8'h00, 32'h0000_00A5, 4'h0, rd, w);
    check("ws_wait_cycles", 32'(w), 32'(WS));
    check("ws_ctrl_before_commit", 32'(ctrl_at_ready), 32'h0);
    check("ws_ctrl_after_commit", 32'(ctrl7), 32'h0000_00A5);

    // Table of single transfers
    foreach (vecs[i]) begin
      link_up7 = vecs[i].link;
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'h0, rd, w);
      check({vecs[i].name, "_waits"}, 32'(w), 32'(WS));
      if (vecs[i].chk_rd) check(vecs[i].name, rd, vecs[i].exp);
    end
    link_up7 = 1'b0;

    // Counter with clear-on-read
    pulse_ev(1, 5);
    apb(1'b0, 8'h14, 32'h0, 4'h0, rd, w);
    check("cnt1_five", rd, 32'd5);
    apb(1'b0, 8'h14, 32'h0, 4'b0010, rd, w);
    check("cnt1_cleared", rd, 32'd0);
    apb(1'b0, 8'h14, 32'h0, 4'h0, rd, w);
    check("cnt1_event_on_clear", rd, 32'd1);
    apb(1'b0, 8'h18, 32'h0, 4'h0, rd, w);
    check("cnt2_idle", rd, 32'd0);

    // Saturation and interrupt masking
    pulse_ev(0, 20);
    apb(1'b0, 8'h10, 32'h0, 4'h0, rd, w);
    check("cnt0_saturated", rd, 32'h0000_000F);
    apb(1'b0, 8'h08, 32'h0, 4'h0, rd, w);
    check("int_status_sat", rd, 32'h0000_0001);
    check("irq_masked", 32'(irq7), 32'h0);
    apb(1'b1, 8'h0C, 32'h0000_0001, 4'h0, rd, w);
    check("irq_at_commit", 32'(irq7), 32'h0);
    @(negedge pclk7);
    check("irq_after_mask", 32'(irq7), 32'h1);

    // W1C racing a saturation event
    pulse_ev(0, 20);
    apb(1'b1, 8'h08, 32'h0000_0001, 4'b0001, rd, w);
    apb(1'b0, 8'h08, 32'h0, 4'h0, rd, w);
    check("w1c_race_status", rd, 32'h0000_0001);
    check("w1c_race_irq", 32'(irq7), 32'h1);
    apb(1'b1, 8'h08, 32'h0000_0001, 4'h0, rd, w);
    check("w1c_irq_lag", 32'(irq7), 32'h1);
    @(negedge pclk7);
    check("w1c_irq_drop", 32'(irq7), 32'h0);
    apb(1'b0, 8'h08, 32'h0, 4'h0, rd, w);
    check("w1c_status_clear", rd, 32'h0);

    // Abort by dropping psel7 mid-wait
    apb(1'b1, 8'h00, 32'h0, 4'h0, rd, w);
    start_ctrl_write(32'h0000_003C);
    check("abort_wait0", 32'(pready7), 32'h0);
    @(negedge pclk7);
    psel7 = 1'b0; penable7 = 1'b0;
    #1;
    check("abort_pready", 32'(pready7), 32'h0);
    repeat (3) @(negedge pclk7);
    check("abort_ctrl7", 32'(ctrl7), 32'h0);
    apb(1'b0, 8'h00, 32'h0, 4'h0, rd, w);
    check("abort_recover_rd", rd, 32'h0);
    check("abort_recover_waits", 32'(w), 32'(WS));

    // Reset mid-transfer
    start_ctrl_write(32'h0000_003C);
    @(negedge pclk7);
    preset7 = 1'b1;
    @(negedge pclk7);
    preset7 = 1'b0;
    #1;
    check("rstmid_pready", 32'(pready7), 32'h0);
    psel7 = 1'b0; penable7 = 1'b0; pwrite7 = 1'b0;
    @(negedge pclk7);
    check("rstmid_ctrl7", 32'(ctrl7), 32'h0);
    check("rstmid_irq7", 32'(irq7), 32'h0);
    apb(1'b0, 8'h00, 32'h0, 4'h0, rd, w);
    check("rstmid_recover_rd", rd, 32'h0);
    check("rstmid_recover_waits", 32'(w), 32'(WS));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
